// File: rtl/vram_arb_pkg.sv
// ============================================================================
// vram_arb_pkg : shared state encoding, register map and status bit indices
// Revision     : 1.0
// ============================================================================
`default_nettype none

package vram_arb_pkg;

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_HREQ = 2'd1;
  localparam logic [1:0] c_ST_DMA  = 2'd2;
  localparam logic [1:0] c_ST_TURN = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = c_ST_IDLE,
    ST_HREQ = c_ST_HREQ,
    ST_DMA  = c_ST_DMA,
    ST_TURN = c_ST_TURN
  } arb_state_t;

  localparam logic [1:0] c_REG_STATUS = 2'd0;
  localparam logic [1:0] c_REG_CNT_HI = 2'd1;
  localparam logic [1:0] c_REG_CNT_LO = 2'd2;
  localparam logic [1:0] c_REG_CNT_CL = 2'd3;

  localparam int c_BIT_WDF = 7;
  localparam int c_BIT_WIE = 6;
  localparam int c_BIT_ERR = 5;
  localparam int c_BIT_GNT = 0;

endpackage

`default_nettype wire

// File: rtl/arb_watchdog.sv
// ============================================================================
// arb_watchdog : hold-duration counter with a sticky overrun flag
// Revision     : 1.0
// ============================================================================
`default_nettype none

module arb_watchdog #(
  parameter int MAX_HOLD = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic vpu_hold,
  input  logic clr,
  output logic wdf
);

  localparam int            c_W     = $clog2(MAX_HOLD + 1);
  localparam logic [c_W-1:0] c_LIMIT = c_W'(MAX_HOLD);
  localparam logic [c_W-1:0] c_PRE   = c_W'(MAX_HOLD - 1);

  logic [c_W-1:0] r_cnt;
  logic           r_wdf;
  logic           w_hit;

  // Counter parks at the limit so a cleared flag is not re-armed by the same hold.
  assign w_hit = vpu_hold && (r_cnt == c_PRE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_wdf <= 1'b0;
    end else begin
      if (!vpu_hold)
        r_cnt <= '0;
      else if (r_cnt != c_LIMIT)
        r_cnt <= r_cnt + c_W'(1);

      if (w_hit)
        r_wdf <= 1'b1;
      else if (clr)
        r_wdf <= 1'b0;
    end
  end

  assign wdf = r_wdf;

endmodule

`default_nettype wire

// File: rtl/vram_arbiter.sv
// ============================================================================
// vram_arbiter : CPU / VPU-DMA memory port arbiter with stolen-cycle counter
// Revision     : 1.0
// ============================================================================
`default_nettype none

module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int MAX_HOLD = 1023,
  parameter int CNT_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_rw,
  input  logic        cpu_vma,
  input  logic        cpu_ba,
  output logic        cpu_halt,
  input  logic        vpu_hold,
  input  logic        vpu_vramcs,
  input  logic [15:0] vpu_addr,
  output logic [7:0]  vpu_data,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_cs,
  input  logic [7:0]  mem_rdata,
  input  logic [1:0]  AD,
  input  logic [7:0]  DI,
  output logic [7:0]  DO,
  input  logic        rw,
  input  logic        cs,
  output logic        irq
);

  arb_state_t       r_state;
  logic             r_halt;
  logic             r_wie;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_shadow;
  logic [7:0]       r_do;

  logic             w_rd;
  logic             w_wr;
  logic             w_clr_stat;
  logic             w_wdf;
  logic             w_gnt;
  logic [15:0]      w_cnt16;
  logic             w_unused;

  assign w_rd       = cs & rw;
  assign w_wr       = cs & ~rw;
  assign w_clr_stat = w_rd && (AD == c_REG_STATUS);
  assign w_gnt      = (r_state == ST_DMA);
  assign w_cnt16    = 16'(r_cnt);
  assign w_unused   = &{1'b0, DI[7], DI[5:0]};

  // Halt is registered alongside the state so it tracks state != IDLE exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_halt  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (vpu_hold) begin
          r_state <= ST_HREQ;
          r_halt  <= 1'b1;
        end
        ST_HREQ: if (!vpu_hold) begin
          r_state <= ST_IDLE;
          r_halt  <= 1'b0;
        end else if (cpu_ba) begin
          r_state <= ST_DMA;
        end
        ST_DMA: if (!vpu_hold) r_state <= ST_TURN;
        ST_TURN: begin
          r_state <= ST_IDLE;
          r_halt  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_halt  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    mem_addr = cpu_addr;
    mem_cs   = 1'b0;
    mem_we   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        mem_cs = cpu_vma;
        mem_we = cpu_vma & ~cpu_rw;
      end
      ST_DMA: begin
        mem_addr = vpu_addr;
        mem_cs   = vpu_vramcs;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wie    <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_do     <= '0;
    end else begin
      if (vpu_vramcs && (r_state != ST_DMA))
        r_err <= 1'b1;
      else if (w_clr_stat)
        r_err <= 1'b0;

      if (w_wr && (AD == c_REG_STATUS))
        r_wie <= DI[c_BIT_WIE];

      if (w_wr && (AD == c_REG_CNT_CL))
        r_cnt <= '0;
      else if ((r_state != ST_IDLE) && (r_cnt != {CNT_W{1'b1}}))
        r_cnt <= r_cnt + CNT_W'(1);

      if (w_rd) begin
        case (AD)
          c_REG_STATUS: begin
            r_do            <= '0;
            r_do[c_BIT_WDF] <= w_wdf;
            r_do[c_BIT_WIE] <= r_wie;
            r_do[c_BIT_ERR] <= r_err;
            r_do[c_BIT_GNT] <= w_gnt;
          end
          c_REG_CNT_HI: begin
            r_do     <= w_cnt16[15:8];
            r_shadow <= w_cnt16[7:0];
          end
          c_REG_CNT_LO: r_do <= r_shadow;
          default:      r_do <= '0;
        endcase
      end
    end
  end

  arb_watchdog #(
    .MAX_HOLD (MAX_HOLD)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .vpu_hold (vpu_hold),
    .clr      (w_clr_stat),
    .wdf      (w_wdf)
  );

  assign cpu_halt  = r_halt;
  assign mem_wdata = cpu_wdata;
  assign vpu_data  = mem_rdata;
  assign DO        = r_do;
  assign irq       = w_wdf & r_wie;

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// ============================================================================
// tb_vram_arbiter : directed bench for vram_arbiter (MAX_HOLD=8, CNT_W=16)
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rw;
  logic        cpu_vma;
  logic        cpu_ba;
  logic        cpu_halt;
  logic        vpu_hold;
  logic        vpu_vramcs;
  logic [15:0] vpu_addr;
  logic [7:0]  vpu_data;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_cs;
  logic [7:0]  mem_rdata;
  logic [1:0]  AD;
  logic [7:0]  DI;
  logic [7:0]  DO;
  logic        rw;
  logic        cs;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  vram_arbiter #(
    .MAX_HOLD (8),
    .CNT_W    (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rw     (cpu_rw),
    .cpu_vma    (cpu_vma),
    .cpu_ba     (cpu_ba),
    .cpu_halt   (cpu_halt),
    .vpu_hold   (vpu_hold),
    .vpu_vramcs (vpu_vramcs),
    .vpu_addr   (vpu_addr),
    .vpu_data   (vpu_data),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_cs     (mem_cs),
    .mem_rdata  (mem_rdata),
    .AD         (AD),
    .DI         (DI),
    .DO         (DO),
    .rw         (rw),
    .cs         (cs),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_rd(input logic [1:0] a);
    cs = 1'b1; rw = 1'b1; AD = a;
    tick();
    cs = 1'b0;
  endtask

  task automatic reg_wr(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; rw = 1'b0; AD = a; DI = d;
    tick();
    cs = 1'b0; rw = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_rw = 1'b1; cpu_vma = 1'b0;
    cpu_ba = 1'b0; vpu_hold = 1'b0; vpu_vramcs = 1'b0; vpu_addr = '0;
    mem_rdata = '0; AD = '0; DI = '0; rw = 1'b1; cs = 1'b0;
    do_reset();

    check("rst_halt", 32'(cpu_halt), 32'd0);
    check("rst_do",   32'(DO),       32'h00);
    check("rst_irq",  32'(irq),      32'd0);
    check("rst_cs",   32'(mem_cs),   32'd0);

    // Basic grant
    cpu_addr = 16'h1234; cpu_wdata = 8'h5A; cpu_rw = 1'b0; cpu_vma = 1'b1;
    vpu_addr = 16'hBEEF; mem_rdata = 8'hA5;
    #1;
    check("idle_addr",  32'(mem_addr),  32'h1234);
    check("idle_cs",    32'(mem_cs),    32'd1);
    check("idle_we",    32'(mem_we),    32'd1);
    check("idle_wdata", 32'(mem_wdata), 32'h5A);
    check("vdata",      32'(vpu_data),  32'hA5);
    vpu_hold = 1'b1;
    #1;
    check("t0_cs_inflight", 32'(mem_cs),   32'd1);
    check("t0_halt",        32'(cpu_halt), 32'd0);
    tick();
    check("t1_halt", 32'(cpu_halt), 32'd1);
    check("t1_cs",   32'(mem_cs),   32'd0);
    check("t1_we",   32'(mem_we),   32'd0);
    check("t1_addr", 32'(mem_addr), 32'h1234);
    tick();
    check("t2_cs", 32'(mem_cs), 32'd0);
    cpu_ba = 1'b1;
    tick();
    vpu_vramcs = 1'b1;
    #1;
    check("dma_addr", 32'(mem_addr), 32'hBEEF);
    check("dma_cs",   32'(mem_cs),   32'd1);
    check("dma_we",   32'(mem_we),   32'd0);
    reg_rd(2'd0);
    check("dma_gnt", 32'(DO), 32'h01);
    vpu_hold = 1'b0; vpu_vramcs = 1'b0; cpu_ba = 1'b0;
    tick();
    check("turn_halt", 32'(cpu_halt), 32'd1);
    check("turn_cs",   32'(mem_cs),   32'd0);
    check("turn_addr", 32'(mem_addr), 32'h1234);
    tick();
    check("back_halt", 32'(cpu_halt), 32'd0);
    check("back_cs",   32'(mem_cs),   32'd1);

    // Hold abort
    cpu_rw = 1'b1; vpu_hold = 1'b1;
    tick();
    check("abort_halt", 32'(cpu_halt), 32'd1);
    check("abort_cs",   32'(mem_cs),   32'd0);
    vpu_hold = 1'b0;
    tick();
    check("abort_idle_halt", 32'(cpu_halt), 32'd0);
    check("abort_idle_cs",   32'(mem_cs),   32'd1);
    reg_rd(2'd0);
    check("abort_status", 32'(DO), 32'h00);

    // Protocol error
    cpu_vma = 1'b0; vpu_vramcs = 1'b1;
    #1;
    check("perr_cs", 32'(mem_cs), 32'd0);
    tick();
    vpu_vramcs = 1'b0;
    reg_rd(2'd0);
    check("perr_err", 32'(DO), 32'h20);
    reg_rd(2'd0);
    check("perr_clr", 32'(DO), 32'h00);

    // Watchdog
    do_reset();
    reg_wr(2'd0, 8'h40);
    vpu_hold = 1'b1; cpu_ba = 1'b1;
    repeat (7) tick();
    check("wd_irq_pre", 32'(irq), 32'd0);
    tick();
    check("wd_irq", 32'(irq), 32'd1);
    reg_rd(2'd0);
    check("wd_status", 32'(DO),  32'hC1);
    check("wd_irq_clr", 32'(irq), 32'd0);
    reg_rd(2'd0);
    check("wd_keep_gnt", 32'(DO), 32'h41);

    // Reset mid-DMA
    cpu_addr = 16'h4321; cpu_vma = 1'b1; cpu_rw = 1'b1;
    rst = 1'b1;
    tick();
    check("rstdma_halt", 32'(cpu_halt), 32'd0);
    check("rstdma_do",   32'(DO),       32'h00);
    check("rstdma_addr", 32'(mem_addr), 32'h4321);
    check("rstdma_cs",   32'(mem_cs),   32'd1);
    vpu_hold = 1'b0; cpu_ba = 1'b0; cpu_vma = 1'b0;
    rst = 1'b0;

    // Stolen-cycle counter: after k ticks of held bus the count is k-1
    do_reset();
    vpu_hold = 1'b1; cpu_ba = 1'b1;
    repeat (101) tick();
    reg_rd(2'd1);
    check("cnt100_hi", 32'(DO), 32'h00);
    reg_rd(2'd2);
    check("cnt100_lo", 32'(DO), 32'h64);
    repeat (153) tick();
    reg_rd(2'd1);
    check("cnt255_hi", 32'(DO), 32'h00);
    reg_rd(2'd2);
    check("cnt255_lo_coherent", 32'(DO), 32'hFF);
    reg_rd(2'd1);
    check("cnt257_hi", 32'(DO), 32'h01);
    reg_rd(2'd2);
    check("cnt257_lo", 32'(DO), 32'h01);
    reg_wr(2'd3, 8'h00);
    reg_rd(2'd1);
    check("cntclr_hi", 32'(DO), 32'h00);
    reg_rd(2'd2);
    check("cntclr_lo", 32'(DO), 32'h00);
    repeat (65600) tick();
    reg_rd(2'd1);
    check("cntsat_hi", 32'(DO), 32'hFF);
    reg_rd(2'd2);
    check("cntsat_lo", 32'(DO), 32'hFF);
    reg_rd(2'd3);
    check("reg3_rd", 32'(DO), 32'h00);
    vpu_hold = 1'b0; cpu_ba = 1'b0;
    tick();
    tick();
    check("end_halt", 32'(cpu_halt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
